// File: rtl/cdb_pkg.sv
// Shared widths, constants and payload type for the common data bus broadcaster.
package cdb_pkg;
  localparam int unsigned NUM_SRC   = 4;
  localparam int unsigned ROB_W     = 6;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ROB_DEPTH = 16;
  localparam int unsigned PTR_W     = $clog2(NUM_SRC);

  localparam logic [ROB_W-1:0] ROB_INVALID = ROB_W'(16);

  typedef struct packed {
    logic [ROB_W-1:0]  rob;
    logic [DATA_W-1:0] data;
  } cdb_msg_t;

  localparam cdb_msg_t CDB_IDLE = '{rob: ROB_INVALID, data: '0};

  // Only indices inside the ROB are ever broadcast.
  function automatic logic rob_is_valid(input logic [ROB_W-1:0] rob);
    return rob < ROB_W'(ROB_DEPTH);
  endfunction
endpackage

// File: rtl/cdb_broadcaster_if.sv
// Functional-unit result handshake plus the two CDB broadcast channels.
interface cdb_broadcaster_if;
  import cdb_pkg::*;

  logic [NUM_SRC-1:0]             src_valid;
  logic [NUM_SRC-1:0]             src_ready;
  logic [NUM_SRC-1:0][ROB_W-1:0]  src_rob;
  logic [NUM_SRC-1:0][DATA_W-1:0] src_data;

  logic              CDBisCast1;
  logic              CDBisCast2;
  logic [ROB_W-1:0]  CDBrobNum1;
  logic [ROB_W-1:0]  CDBrobNum2;
  logic [DATA_W-1:0] CDBdata1;
  logic [DATA_W-1:0] CDBdata2;

  modport master (
    output src_valid, src_rob, src_data,
    input  src_ready,
    input  CDBisCast1, CDBisCast2, CDBrobNum1, CDBrobNum2, CDBdata1, CDBdata2
  );

  modport slave (
    input  src_valid, src_rob, src_data,
    output src_ready,
    output CDBisCast1, CDBisCast2, CDBrobNum1, CDBrobNum2, CDBdata1, CDBdata2
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Round-robin picker of up to two requesters, scanning upward from ptr.
module rr_arbiter2
  import cdb_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  input  logic [1:0]         n_free,
  output logic [NUM_SRC-1:0] gnt_first_c,
  output logic [NUM_SRC-1:0] gnt_second_c,
  output logic [PTR_W-1:0]   ptr_next_c
);
  logic [1:0]       n_won;
  logic [PTR_W-1:0] idx;

  // Index wraps naturally because NUM_SRC is a power of two.
  always_comb begin
    gnt_first_c  = '0;
    gnt_second_c = '0;
    ptr_next_c   = ptr;
    n_won        = '0;
    idx          = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      idx = ptr + PTR_W'(k);
      if (req[idx] && (n_won < n_free)) begin
        if (n_won == 2'd0) gnt_first_c[idx]  = 1'b1;
        else               gnt_second_c[idx] = 1'b1;
        n_won      = n_won + 2'd1;
        ptr_next_c = idx + PTR_W'(1);
      end
    end
  end
endmodule

// File: rtl/cdb_broadcaster.sv
// Holds one result per functional unit and casts them round-robin on two CDB channels.
// Optional saturating broadcast/wait counters when CDB_STATS_EN is defined.
module cdb_broadcaster
  import cdb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cataclysm,
  cdb_broadcaster_if.slave  bus
`ifdef CDB_STATS_EN
  ,
  output logic [15:0]       cdb_cast_cnt,
  output logic [15:0]       cdb_wait_cnt
`endif
);
  logic [NUM_SRC-1:0]   held_q;
  cdb_msg_t [NUM_SRC-1:0] slot_q;
  logic [NUM_SRC-1:0]   accept;
  logic [NUM_SRC-1:0]   rob_ok;
  logic [NUM_SRC-1:0]   gnt_first;
  logic [NUM_SRC-1:0]   gnt_second;
  logic [NUM_SRC-1:0]   gnt1;
  logic [NUM_SRC-1:0]   gnt2;
  logic [PTR_W-1:0]     ptr_q;
  logic [PTR_W-1:0]     ptr_next;
  logic                 cast1_q;
  logic                 cast2_q;
  logic                 free1;
  logic                 free2;
  logic [1:0]           n_free;
  cdb_msg_t             msg1_q;
  cdb_msg_t             msg2_q;

  function automatic cdb_msg_t pick(input cdb_msg_t [NUM_SRC-1:0] slots,
                                    input logic [NUM_SRC-1:0] sel);
    cdb_msg_t m;
    m = CDB_IDLE;
    for (int unsigned i = 0; i < NUM_SRC; i++)
      if (sel[i]) m = slots[i];
    return m;
  endfunction

  always_comb begin
    rob_ok = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++)
      rob_ok[i] = rob_is_valid(bus.src_rob[i]);
  end

  assign accept = bus.src_valid & ~held_q;

  // A channel that cast this cycle must drop its strobe, so it sits out the next edge.
  assign free1  = ~cast1_q;
  assign free2  = ~cast2_q;
  assign n_free = 2'(free1) + 2'(free2);

  rr_arbiter2 u_arb (
    .req          (held_q),
    .ptr          (ptr_q),
    .n_free       (n_free),
    .gnt_first_c  (gnt_first),
    .gnt_second_c (gnt_second),
    .ptr_next_c   (ptr_next)
  );

  // First winner takes the lowest free channel; the second only exists when both are free.
  assign gnt1 = free1 ? gnt_first  : '0;
  assign gnt2 = free1 ? gnt_second : gnt_first;

  always_ff @(posedge clk) begin
    if (rst) begin
      held_q  <= '0;
      ptr_q   <= '0;
      cast1_q <= 1'b0;
      cast2_q <= 1'b0;
      msg1_q  <= CDB_IDLE;
      msg2_q  <= CDB_IDLE;
    end else if (cataclysm) begin
      held_q  <= '0;
      cast1_q <= 1'b0;
      cast2_q <= 1'b0;
      msg1_q  <= CDB_IDLE;
      msg2_q  <= CDB_IDLE;
    end else begin
      held_q  <= (held_q & ~(gnt1 | gnt2)) | (accept & rob_ok);
      ptr_q   <= ptr_next;
      cast1_q <= |gnt1;
      cast2_q <= |gnt2;
      msg1_q  <= (|gnt1) ? pick(slot_q, gnt1) : CDB_IDLE;
      msg2_q  <= (|gnt2) ? pick(slot_q, gnt2) : CDB_IDLE;
    end
  end

  // Payload is only meaningful while held, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_SRC; i++)
      if (accept[i]) slot_q[i] <= '{rob: bus.src_rob[i], data: bus.src_data[i]};
  end

  assign bus.src_ready  = ~held_q;
  assign bus.CDBisCast1 = cast1_q;
  assign bus.CDBisCast2 = cast2_q;
  assign bus.CDBrobNum1 = msg1_q.rob;
  assign bus.CDBrobNum2 = msg2_q.rob;
  assign bus.CDBdata1   = msg1_q.data;
  assign bus.CDBdata2   = msg2_q.data;

`ifdef CDB_STATS_EN
  localparam int unsigned CNT_W = 16;

  logic [CNT_W-1:0] cast_cnt_q;
  logic [CNT_W-1:0] wait_cnt_q;
  logic [1:0]       n_cast;
  logic             any_wait;
  logic [CNT_W:0]   cast_sum;
  logic [CNT_W:0]   wait_sum;

  assign n_cast   = cataclysm ? 2'd0 : 2'(|gnt1) + 2'(|gnt2);
  assign any_wait = cataclysm ? (|held_q) : (|(held_q & ~(gnt1 | gnt2)));
  assign cast_sum = (CNT_W+1)'(cast_cnt_q) + (CNT_W+1)'(n_cast);
  assign wait_sum = (CNT_W+1)'(wait_cnt_q) + (CNT_W+1)'(any_wait);

  always_ff @(posedge clk) begin
    if (rst) begin
      cast_cnt_q <= '0;
      wait_cnt_q <= '0;
    end else begin
      cast_cnt_q <= cast_sum[CNT_W] ? '1 : cast_sum[CNT_W-1:0];
      wait_cnt_q <= wait_sum[CNT_W] ? '1 : wait_sum[CNT_W-1:0];
    end
  end

  assign cdb_cast_cnt = cast_cnt_q;
  assign cdb_wait_cnt = wait_cnt_q;
`endif
endmodule
